// File: rtl/fpu_result_sink.sv
// Receive-side buffer for FPU results: in-order FIFO of result words plus flags,
// with sticky accumulated exception flags and a trap raised by enabled exceptions.
module fpu_result_sink #(
   parameter int FLOAT_SIZE = 32,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [FLOAT_SIZE-1:0]        in_result,
   input  logic [4:0]                   in_flags,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [FLOAT_SIZE-1:0]        out_result,
   output logic [4:0]                   out_flags,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [4:0]                   fflags,
   input  logic                         fflags_clr,
   input  logic [4:0]                   trap_en,
   output logic                         trap
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [FLOAT_SIZE-1:0] mem_result [DEPTH];
   logic [4:0]            mem_flags  [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  push;
   logic                  pop;

   // Handshake outputs depend only on registered occupancy.
   assign in_ready  = (count < CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_result = out_valid ? mem_result[rd_ptr] : '0;
   assign out_flags  = out_valid ? mem_flags[rd_ptr]  : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_result[wr_ptr] <= in_result;
         mem_flags[wr_ptr]  <= in_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         fflags <= '0;
         trap   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // Clear takes effect before a same-cycle push contributes its flags.
         fflags <= (fflags_clr ? 5'b0 : fflags) | (push ? in_flags : 5'b0);
         trap   <= (fflags_clr ? 1'b0 : trap) | (push & (|(in_flags & trap_en)));
      end
   end

endmodule

// File: tb/tb_fpu_result_sink.sv
// Directed self-checking bench for fpu_result_sink (FLOAT_SIZE=32, DEPTH=4).
module tb_fpu_result_sink;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [4:0]  in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_flags;
   logic [2:0]  count;
   logic [4:0]  fflags;
   logic        fflags_clr;
   logic [4:0]  trap_en;
   logic        trap;

   int checks = 0;
   int errors = 0;

   fpu_result_sink #(.FLOAT_SIZE(32), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_flags   (in_flags),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .count      (count),
      .fflags     (fflags),
      .fflags_clr (fflags_clr),
      .trap_en    (trap_en),
      .trap       (trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h exp 0", out_result); end
      checks++; if (fflags !== 5'b0 || trap !== 1'b0) begin errors++; $display("FAIL reset_sticky got fflags=%b trap=%b exp 0/0", fflags, trap); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_result = 32'h3F80_0000; in_flags = 5'b0;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
      checks++; if (out_result !== 32'h3F80_0000) begin errors++; $display("FAIL single_out_result got %h exp 3f800000", out_result); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
      checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL single_fflags got %b exp 00000", fflags); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || count !== 3'd0) begin
         errors++; $display("FAIL single_pop got valid=%b result=%h count=%0d exp 0/0/0", out_valid, out_result, count);
      end
   endtask

   task automatic test_fill_drain();
      for (int r = 0; r < 3; r++) begin
         for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_result = (r << 8) | i; in_flags = 5'(i);
            tick();
         end
         checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full r%0d got count=%0d in_ready=%b exp 4/0", r, count, in_ready);
         end
         in_result = 32'h5; in_flags = 5'b0;
         tick();
         in_valid = 1'b0;
         checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_drop_count r%0d got %0d exp 4", r, count); end
         out_ready = 1'b1;
         for (int i = 1; i <= 4; i++) begin
            checks++; if (out_result !== ((r << 8) | i) || out_flags !== 5'(i)) begin
               errors++; $display("FAIL drain_order r%0d i%0d got %h/%b exp %h/%b", r, i, out_result, out_flags, (r << 8) | i, 5'(i));
            end
            tick();
         end
         out_ready = 1'b0;
         checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL drain_empty r%0d got valid=%b count=%0d exp 0/0", r, out_valid, count);
         end
      end
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_result = 32'h11 + i; in_flags = 5'b0;
         tick();
      end
      in_result = 32'h99; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin
         errors++; $display("FAIL full_pop_count got count=%0d in_ready=%b exp 3/1", count, in_ready);
      end
      for (int i = 1; i < 4; i++) begin
         checks++; if (out_result !== 32'h11 + i) begin
            errors++; $display("FAIL full_pop_order i%0d got %h exp %h", i, out_result, 32'h11 + i);
         end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_pop_empty got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_flags = 5'b0;
      in_result = 32'hA0; tick();
      in_result = 32'hA1; tick();
      for (int k = 0; k < 10; k++) begin
         checks++; if (out_result !== 32'hA0 + k) begin
            errors++; $display("FAIL b2b_head k%0d got %h exp %h", k, out_result, 32'hA0 + k);
         end
         in_result = 32'hA2 + k; out_ready = 1'b1;
         tick();
         checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count k%0d got %0d exp 2", k, count); end
      end
      in_valid = 1'b0;
      checks++; if (out_result !== 32'hAA) begin errors++; $display("FAIL b2b_tail0 got %h exp aa", out_result); end
      tick();
      checks++; if (out_result !== 32'hAB) begin errors++; $display("FAIL b2b_tail1 got %h exp ab", out_result); end
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
   endtask

   task automatic test_sticky();
      fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
      checks++; if (fflags !== 5'b0) begin errors++; $display("FAIL sticky_clear got %b exp 00000", fflags); end
      in_valid = 1'b1; in_result = 32'h1; in_flags = 5'b00001; tick();
      in_result = 32'h2; in_flags = 5'b00100; tick();
      checks++; if (fflags !== 5'b00101) begin errors++; $display("FAIL sticky_accum got %b exp 00101", fflags); end
      in_result = 32'h3; in_flags = 5'b10000; fflags_clr = 1'b1; tick();
      in_valid = 1'b0; fflags_clr = 1'b0;
      checks++; if (fflags !== 5'b10000 || trap !== 1'b0) begin
         errors++; $display("FAIL sticky_clr_push got fflags=%b trap=%b exp 10000/0", fflags, trap);
      end
      out_ready = 1'b1;
      checks++; if (out_flags !== 5'b00001) begin errors++; $display("FAIL sticky_fifo0 got %b exp 00001", out_flags); end
      tick();
      checks++; if (out_flags !== 5'b00100) begin errors++; $display("FAIL sticky_fifo1 got %b exp 00100", out_flags); end
      tick();
      checks++; if (out_flags !== 5'b10000) begin errors++; $display("FAIL sticky_fifo2 got %b exp 10000", out_flags); end
      tick();
      out_ready = 1'b0;
      checks++; if (fflags !== 5'b10000 || count !== 3'd0) begin
         errors++; $display("FAIL sticky_after_pop got fflags=%b count=%0d exp 10000/0", fflags, count);
      end
   endtask

   task automatic test_trap();
      fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
      trap_en = 5'b01000;
      in_valid = 1'b1; in_result = 32'h7; in_flags = 5'b00001; tick();
      in_valid = 1'b0;
      checks++; if (trap !== 1'b0) begin errors++; $display("FAIL trap_masked got %b exp 0", trap); end
      in_valid = 1'b1; in_flags = 5'b01000; tick();
      in_valid = 1'b0;
      checks++; if (trap !== 1'b1) begin errors++; $display("FAIL trap_set got %b exp 1", trap); end
      trap_en = 5'b00000; tick();
      checks++; if (trap !== 1'b1) begin errors++; $display("FAIL trap_hold got %b exp 1", trap); end
      fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
      checks++; if (trap !== 1'b0 || fflags !== 5'b0) begin
         errors++; $display("FAIL trap_clear got trap=%b fflags=%b exp 0/00000", trap, fflags);
      end
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL trap_fifo_kept got %0d exp 2", count); end
      out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      trap_en = 5'b00010;
      in_valid = 1'b1; in_flags = 5'b00000;
      in_result = 32'hC0; tick();
      in_result = 32'hC1; in_flags = 5'b00010; tick();
      in_result = 32'hC2; in_flags = 5'b00000; tick();
      in_valid = 1'b0;
      checks++; if (count !== 3'd3 || trap !== 1'b1) begin
         errors++; $display("FAIL arst_setup got count=%0d trap=%b exp 3/1", count, trap);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 5'b0) begin
         errors++; $display("FAIL arst_fifo got count=%0d valid=%b result=%h flags=%b exp 0", count, out_valid, out_result, out_flags);
      end
      checks++; if (fflags !== 5'b0 || trap !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL arst_sticky got fflags=%b trap=%b in_ready=%b exp 0/0/1", fflags, trap, in_ready);
      end
      tick();
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
         errors++; $display("FAIL arst_pop got valid=%b count=%0d exp 0/0", out_valid, count);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0;
      out_ready = 1'b0; fflags_clr = 1'b0; trap_en = '0;
      test_reset();
      test_single();
      test_fill_drain();
      test_full_pop();
      test_back_to_back();
      test_sticky();
      test_trap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
